// File: rtl/alu_pkg.sv
// Shared ALU constants: serial-adder FSM encoding, default datapath width
// and the helper that sizes the serial bit counter.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } add_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Bit counter must be able to represent 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int ADD_CNT_W = cnt_width(ALU_WIDTH);

endpackage

// File: rtl/serial_adder32_full_adder.sv
// One-bit full-adder cell; the additive counterpart of fullsubtractor
// (Bout, Diff, A, B, Bin) with the same port ordering.
module full_Adder (
  output logic c_out,
  output logic Sum,
  input  logic A,
  input  logic B,
  input  logic c_in
);

  assign Sum   = A ^ B ^ c_in;
  assign c_out = (A & B) | (c_in & (A ^ B));

endmodule

// File: rtl/serial_adder32.sv
// Bit-serial adder: one full-adder cell processes one bit per cycle,
// LSB first, and results are held from the done pulse until the next start.
module serial_adder32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  add_state_e       state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cell_sum, cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shifted;

  full_Adder u_cell (
    .c_out (cell_cout),
    .Sum   (cell_sum),
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .c_in  (carry)
  );

  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
  assign sum_shifted = {cell_sum, sum[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first keeps this block purely combinational
  // (no latch) for any state/input combination.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = FIN;
      FIN:                   state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // done trails FIN by one register stage, so a reset during FIN kills it.
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= sum_shifted;
          carry <= cell_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout <= cell_cout;
            ovf  <= carry ^ cell_cout;
            zero <= (sum_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder32.sv
// Directed bench for serial_adder32: vector table for arithmetic results,
// hand-written sequences for reset, start-during-run and back-to-back cases.
module tb_serial_adder32;

  localparam int W       = 32;
  localparam int LAT     = W + 1;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the accepting edge; lat = edges from acceptance.
  task automatic wait_done(input logic scramble, output int lat);
    lat = -1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == 1) check("busy_in_run", busy, 1);
      if (done) begin
        lat = k;
        break;
      end
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
    start = 1'b1;
    a     = va;
    b     = vb;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    wait_done(1'b1, lat);
  endtask

  task automatic count_idle_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int n;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum",  sum,  0);
    check("reset_zero", zero, 0);
    start = 1'b0;
    rst_n = 1'b1;
    check("reset_start_ignored", busy, 0);
    count_idle_done(40, n);
    check("idle_no_done", n, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, lat);
      check("latency",   lat,  LAT);
      check("sum",       sum,  vecs[i].sum);
      check("cout",      cout, vecs[i].cout);
      check("ovf",       ovf,  vecs[i].ovf);
      check("zero",      zero, vecs[i].zero);
      check("busy_done", busy, 0);
      tick();
      check("done_pulse", done, 0);
      repeat (3) tick();
      check("sum_hold",  sum,  vecs[i].sum);
      check("cout_hold", cout, vecs[i].cout);
    end

    // start held through RUN/FIN with changing operands, then back-to-back.
    start = 1'b1;
    a     = 32'h0000_0005;
    b     = 32'h0000_0003;
    tick();
    wait_done(1'b1, lat);
    check("hold_start_latency", lat, LAT);
    check("hold_start_sum",     sum, 32'h0000_0008);
    a = 32'h0000_0100;
    b = 32'h0000_0023;
    tick();
    start = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    wait_done(1'b0, lat);
    check("b2b_latency", lat, LAT);
    check("b2b_sum",     sum, 32'h0000_0123);
    check("b2b_zero",    zero, 0);

    // Reset asserted during RUN cycle 16 aborts the operation.
    repeat (2) tick();
    start = 1'b1;
    a     = 32'h0000_0002;
    b     = 32'h0000_0002;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_sum",  sum,  0);
    rst_n = 1'b1;
    count_idle_done(40, n);
    check("abort_no_done", n, 0);
    apply(32'h0000_0002, 32'h0000_0002, lat);
    check("post_abort_latency", lat, LAT);
    check("post_abort_sum",     sum, 32'h0000_0004);
    check("post_abort_cout",    cout, 0);

    // Reset during FIN: no done pulse follows.
    tick();
    start = 1'b1;
    a     = 32'h0000_0001;
    b     = 32'h0000_0001;
    tick();
    start = 1'b0;
    repeat (W) tick();
    check("fin_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("fin_abort_done", done, 0);
    count_idle_done(5, n);
    check("fin_abort_no_done", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
